// File: rtl/fetch_requester_pkg.sv
// Shared widths, reset defaults and entry layout for the instruction fetch requester.
package fetch_requester_pkg;

    localparam int          XLEN             = 32;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
    localparam int          ENTRY_W          = 2 * XLEN;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, word} entries; flush empties it in one cycle.
module fetch_buffer #(
    parameter int DATA_W    = 64,
    parameter int BUF_DEPTH = 2,
    localparam int PTR_W    = $clog2(BUF_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] storage [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                storage[wr_ptr] <= data_in;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign data_out = storage[rd_ptr];

endmodule

// File: rtl/fetch_requester.sv
// Instruction fetch initiator: owns the PC, reads one word per cycle and queues it for decode.
module fetch_requester
    import fetch_requester_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [XLEN-1:0]  pc;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             full;
    logic             fetch_en;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    assign pop      = instr_valid && instr_ready;
    assign full     = (count == CNT_W'(BUF_DEPTH));
    // A pop frees a slot in the same cycle, so a full buffer still fetches when decode drains.
    assign fetch_en = !redirect_valid && (!full || pop);

    assign push_entry.pc   = pc;
    assign push_entry.word = mem_data_in;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= align_pc(redirect_pc);
        end else if (fetch_en) begin
            pc <= pc + XLEN'(INSTR_BYTES);
        end
    end

    fetch_buffer #(
        .DATA_W    (ENTRY_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (fetch_en),
        .pop      (pop),
        .flush    (redirect_valid),
        .data_in  (push_entry),
        .data_out (head_entry),
        .count    (count)
    );

    assign instr_valid    = (count != '0);
    assign instr          = head_entry.word;
    assign instr_pc       = head_entry.pc;
    assign mem_address    = pc;
    assign mem_read_write = 1'b0;
    assign mem_data_out   = '0;

endmodule

// File: tb/tb_fetch_requester.sv
// Self-checking bench for fetch_requester against a queue-based reference model.
module tb_fetch_requester;

    localparam logic [31:0] RST_PC = 32'h0100_0000;
    localparam int          DEPTH  = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int          n_checks = 0;
    int          n_fail   = 0;
    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] prev_addr;

    always #5 clock = ~clock;

    fetch_requester #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .mem_address    (mem_address),
        .mem_read_write (mem_read_write),
        .mem_data_out   (mem_data_out),
        .mem_data_in    (mem_data_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0100_0000: return 32'h1111_1111;
            32'h0100_0004: return 32'h2222_2222;
            32'h0100_0008: return 32'h3333_3333;
            default:       return {a[15:0], a[31:16]} ^ 32'hA5C3_0F69;
        endcase
    endfunction

    always_comb mem_data_in = mem_word(mem_address);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_check();
        check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            check_eq("instr", instr, q[0].word);
            check_eq("instr_pc", instr_pc, q[0].pc);
        end
        check_eq("mem_address", mem_address, m_pc);
        check_eq("mem_read_write", {31'b0, mem_read_write}, 32'd0);
        check_eq("mem_data_out", mem_data_out, 32'd0);
    endtask

    task automatic model_update(input logic rv, input logic [31:0] rpc, input logic rdy);
        bit   do_pop;
        ent_t e;
        do_pop = (q.size() != 0) && rdy;
        if (rv) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else if ((q.size() < DEPTH) || do_pop) begin
            if (do_pop) void'(q.pop_front());
            e.pc   = m_pc;
            e.word = mem_word(m_pc);
            q.push_back(e);
            m_pc = m_pc + 32'd4;
        end else if (do_pop) begin
            void'(q.pop_front());
        end
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clock);
        model_check();
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        @(posedge clock);
        model_update(rv, rpc, rdy);
    endtask

    // Asserts reset between edges, checks the immediate effect, releases after a posedge.
    task automatic async_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("rst_addr", mem_address, RST_PC);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_instr_pc", instr_pc, 32'd0);
        q.delete();
        m_pc           = RST_PC;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        m_pc           = RST_PC;
        repeat (3) @(posedge clock);
        #1;
        check_eq("init_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("init_addr", mem_address, RST_PC);
        check_eq("init_instr", instr, 32'd0);
        check_eq("init_instr_pc", instr_pc, 32'd0);
        #1 reset_n = 1'b1;

        // Streaming from reset with decode always ready.
        step(1'b0, '0, 1'b1);
        #1;
        check_eq("s0_pc", instr_pc, 32'h0100_0000);
        check_eq("s0_word", instr, 32'h1111_1111);
        step(1'b0, '0, 1'b1);
        #1;
        check_eq("s1_pc", instr_pc, 32'h0100_0004);
        check_eq("s1_word", instr, 32'h2222_2222);
        step(1'b0, '0, 1'b1);
        #1;
        check_eq("s2_pc", instr_pc, 32'h0100_0008);
        check_eq("s2_word", instr, 32'h3333_3333);
        repeat (3) step(1'b0, '0, 1'b1);

        async_reset();

        // Backpressure from reset: pc freezes after two pushes.
        repeat (5) step(1'b0, '0, 1'b0);
        #1;
        check_eq("bp_addr", mem_address, 32'h0100_0008);
        repeat (6) step(1'b0, '0, 1'b1);

        // Redirect while full, target low bits dropped.
        repeat (3) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h0100_0103, 1'b0);
        #1;
        check_eq("rd_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("rd_addr", mem_address, 32'h0100_0100);
        step(1'b0, '0, 1'b0);
        #1;
        check_eq("rd_valid2", {31'b0, instr_valid}, 32'd1);
        check_eq("rd_pc", instr_pc, 32'h0100_0100);

        // Full buffer drained and refilled in the same cycle keeps pc advancing.
        repeat (2) step(1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1 prev_addr = mem_address;
            step(1'b0, '0, 1'b1);
            #1;
            check_eq("full_adv", mem_address, prev_addr + 32'd4);
        end

        // PC wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFFE, 1'b1);
        #1;
        check_eq("wrap_tgt", mem_address, 32'hFFFF_FFFC);
        step(1'b0, '0, 1'b1);
        #1;
        check_eq("wrap_addr", mem_address, 32'h0000_0000);
        check_eq("wrap_pc", instr_pc, 32'hFFFF_FFFC);

        // Randomized traffic with occasional redirects and resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 3) != 0);
            end
        end

        @(negedge clock);
        model_check();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
